alu_rr_controller: RTL and testbench

- Two-requester round-robin controller that shares one combinational ALU (opcode set 000..111, NUMBITS wide) between requesters 0 and 1.
- Accepts one operation at a time through a valid/ready request handshake.
- Drives registered operands and opcode to the ALU, captures result and flags one cycle later, and returns them on a valid/ready response channel.
- Sits between two datapath clients and the shared ALU instance.

---
 rtl/alu_rr_controller_if.sv | 36 +++
 rtl/alu_rr_controller.sv | 138 +++++++++++++
 tb/tb_alu_rr_controller.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_rr_controller_if.sv
// Requester-side bundle of the shared-ALU controller: two request channels
// and one response channel (result/flags shared, valid/ready per requester).
interface alu_rr_controller_if #(
  parameter int NUMBITS = 16
);
  logic [1:0]         req_valid;
  logic [1:0]         req_ready;
  logic [NUMBITS-1:0] req0_a;
  logic [NUMBITS-1:0] req0_b;
  logic [2:0]         req0_opcode;
  logic [NUMBITS-1:0] req1_a;
  logic [NUMBITS-1:0] req1_b;
  logic [2:0]         req1_opcode;
  logic [1:0]         rsp_valid;
  logic [1:0]         rsp_ready;
  logic [NUMBITS-1:0] rsp_result;
  logic               rsp_carryout;
  logic               rsp_overflow;
  logic               rsp_zero;

  // Client side: issues requests, consumes responses.
  modport master (
    output req_valid, req0_a, req0_b, req0_opcode,
           req1_a, req1_b, req1_opcode, rsp_ready,
    input  req_ready, rsp_valid, rsp_result,
           rsp_carryout, rsp_overflow, rsp_zero
  );

  // Controller side.
  modport slave (
    input  req_valid, req0_a, req0_b, req0_opcode,
           req1_a, req1_b, req1_opcode, rsp_ready,
    output req_ready, rsp_valid, rsp_result,
           rsp_carryout, rsp_overflow, rsp_zero
  );
endinterface

// File: rtl/alu_rr_controller.sv
// Two-requester round-robin front end for one shared combinational ALU.
// One operation in flight: IDLE accepts a request, ISSUE presents registered
// operands to the ALU for one cycle, RESP holds the captured result until the
// owning requester takes it.
module alu_rr_controller #(
  parameter int NUMBITS = 16
) (
  input  logic               clk,
  input  logic               reset,
  alu_rr_controller_if.slave bus,
  output logic [NUMBITS-1:0] alu_a,
  output logic [NUMBITS-1:0] alu_b,
  output logic [2:0]         alu_opcode,
  input  logic [NUMBITS-1:0] alu_result,
  input  logic               alu_carryout,
  input  logic               alu_overflow,
  input  logic               alu_zero,
  output logic               busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  state_t             state;
  state_t             next_state;
  logic               grant;
  logic               last_grant;
  logic               owner;
  logic               req_fire;
  logic               rsp_fire;
  logic [NUMBITS-1:0] rsp_result;
  logic               rsp_carryout;
  logic               rsp_overflow;
  logic               rsp_zero;

  // Round-robin pick: a lone requester wins outright, a tie goes to whoever
  // did not win last time.
  always_comb begin
    grant = 1'b0;
    case (bus.req_valid)
      2'b01:   grant = 1'b0;
      2'b10:   grant = 1'b1;
      2'b11:   grant = ~last_grant;
      default: grant = 1'b0;
    endcase
  end

  // The granted requester is always made ready in IDLE, so any valid
  // request there is a handshake; only the owner's ready retires a response.
  assign req_fire = (state == IDLE) && (|bus.req_valid);
  assign rsp_fire = (state == RESP) && bus.rsp_ready[owner];

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic: ISSUE always lasts exactly one cycle.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (req_fire) next_state = ISSUE;
      ISSUE:   next_state = RESP;
      RESP:    if (rsp_fire) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // FSM outputs: request ready only in IDLE, response valid only in RESP.
  always_comb begin
    bus.req_ready = 2'b00;
    bus.rsp_valid = 2'b00;
    busy          = (state != IDLE);
    if (state == IDLE && (|bus.req_valid)) begin
      bus.req_ready = grant ? 2'b10 : 2'b01;
    end
    if (state == RESP) begin
      bus.rsp_valid = owner ? 2'b10 : 2'b01;
    end
  end

  // Arbitration history and operation owner, updated only on an accepted
  // request; reset leaves last_grant at 1 so requester 0 wins the first tie.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_grant <= 1'b1;
      owner      <= 1'b0;
    end else if (req_fire) begin
      last_grant <= grant;
      owner      <= grant;
    end
  end

  // Operand latch on acceptance and result/flag capture at the end of ISSUE.
  // ALU operands keep their last values between operations.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      alu_a        <= '0;
      alu_b        <= '0;
      alu_opcode   <= '0;
      rsp_result   <= '0;
      rsp_carryout <= 1'b0;
      rsp_overflow <= 1'b0;
      rsp_zero     <= 1'b0;
    end else begin
      if (req_fire) begin
        if (grant) begin
          alu_a      <= bus.req1_a;
          alu_b      <= bus.req1_b;
          alu_opcode <= bus.req1_opcode;
        end else begin
          alu_a      <= bus.req0_a;
          alu_b      <= bus.req0_b;
          alu_opcode <= bus.req0_opcode;
        end
      end
      if (state == ISSUE) begin
        rsp_result   <= alu_result;
        rsp_carryout <= alu_carryout;
        rsp_overflow <= alu_overflow;
        rsp_zero     <= alu_zero;
      end
    end
  end

  assign bus.rsp_result   = rsp_result;
  assign bus.rsp_carryout = rsp_carryout;
  assign bus.rsp_overflow = rsp_overflow;
  assign bus.rsp_zero     = rsp_zero;

endmodule

// File: tb/tb_alu_rr_controller.sv
// Bench for alu_rr_controller with an 8-bit ALU model attached and a
// scoreboard that predicts every response from the accepted request.
module tb_alu_rr_controller;
  localparam int NB = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic [NB-1:0] alu_a, alu_b, alu_res;
  logic [2:0]    alu_opcode;
  logic          alu_c, alu_o, alu_z;
  logic          busy;
  int            vectors = 0;
  int            miscompares = 0;
  int            cyc = 0;

  alu_rr_controller_if #(.NUMBITS(NB)) bus ();

  alu_rr_controller #(.NUMBITS(NB)) dut (
    .clk          (clk),
    .reset        (reset),
    .bus          (bus),
    .alu_a        (alu_a),
    .alu_b        (alu_b),
    .alu_opcode   (alu_opcode),
    .alu_result   (alu_res),
    .alu_carryout (alu_c),
    .alu_overflow (alu_o),
    .alu_zero     (alu_z),
    .busy         (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference ALU: returns {carry, overflow, zero, result}.
  function automatic logic [10:0] ref_alu(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    logic [8:0] s;
    logic [7:0] r;
    logic c, o;
    s = 9'h000; r = 8'h00; c = 1'b0; o = 1'b0;
    case (op)
      3'b000, 3'b001: begin
        s = {1'b0, a} + {1'b0, b}; r = s[7:0]; c = s[8];
        o = (a[7] == b[7]) && (r[7] != a[7]);
      end
      3'b010: begin
        s = {1'b0, a} - {1'b0, b}; r = s[7:0]; c = s[8];
        o = (a[7] != b[7]) && (r[7] != a[7]);
      end
      3'b011: r = ~(a | b);
      3'b100: r = a & b;
      3'b101: r = a | b;
      3'b110: r = a ^ b;
      default: begin r = a >> 1; c = a[0]; end
    endcase
    return {c, o, (r == 8'h00), r};
  endfunction

  // The shared ALU the controller drives.
  always_comb {alu_c, alu_o, alu_z, alu_res} = ref_alu(alu_opcode, alu_a, alu_b);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  typedef struct {
    logic        owner;
    logic [10:0] exp;
  } sb_t;

  sb_t  sb[$];
  int   hs_cyc[$];
  logic model_last;
  logic mg;
  sb_t  ent;
  sb_t  got;

  // Scoreboard: predict on request handshake, compare on response handshake.
  always @(negedge clk) begin
    if (!reset) begin
      sb.delete();
      model_last = 1'b1;
    end else begin
      if (|(bus.req_valid & bus.req_ready)) begin
        mg = (bus.req_valid == 2'b11) ? ~model_last : bus.req_valid[1];
        chk("grant", 32'(bus.req_ready), 32'(mg ? 2'b10 : 2'b01));
        ent.owner = mg;
        ent.exp = mg ? ref_alu(bus.req1_opcode, bus.req1_a, bus.req1_b)
                     : ref_alu(bus.req0_opcode, bus.req0_a, bus.req0_b);
        sb.push_back(ent);
        model_last = mg;
        hs_cyc.push_back(cyc);
      end
      if (|(bus.rsp_valid & bus.rsp_ready)) begin
        chk("sb_nonempty", 32'(sb.size() > 0), 32'h1);
        if (sb.size() > 0) begin
          got = sb.pop_front();
          chk("rsp_owner", 32'(bus.rsp_valid), 32'(got.owner ? 2'b10 : 2'b01));
          chk("rsp_data", 32'({bus.rsp_carryout, bus.rsp_overflow, bus.rsp_zero, bus.rsp_result}),
              32'(got.exp));
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    reset = 1'b0;
    #1;
    @(negedge clk);
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  task automatic drain();
    bus.req_valid = 2'b00;
    bus.rsp_ready = 2'b11;
    for (int i = 0; i < 20 && (busy || sb.size() > 0); i++) step();
    chk("drain_idle", 32'(busy), 32'h0);
    chk("sb_empty", 32'(sb.size()), 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    bus.req_valid = 2'b00; bus.rsp_ready = 2'b00;
    bus.req0_a = '0; bus.req0_b = '0; bus.req0_opcode = '0;
    bus.req1_a = '0; bus.req1_b = '0; bus.req1_opcode = '0;
    step(); step();
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_req_ready", 32'(bus.req_ready), 32'h0);
    chk("rst_alu", 32'({alu_a, alu_b, alu_opcode}), 32'h0);
    chk("rst_rsp", 32'({bus.rsp_carryout, bus.rsp_overflow, bus.rsp_zero, bus.rsp_result}), 32'h0);
    reset = 1'b1;

    // Single request from requester 0: FF + 01
    bus.req_valid = 2'b01; bus.req0_opcode = 3'b000; bus.req0_a = 8'hFF; bus.req0_b = 8'h01;
    #1;
    chk("t1_req_ready", 32'(bus.req_ready), 32'h1);
    step();
    bus.req_valid = 2'b00;
    #1;
    chk("t1_issue_busy", 32'(busy), 32'h1);
    chk("t1_issue_ready", 32'(bus.req_ready), 32'h0);
    chk("t1_alu_ops", 32'({alu_a, alu_b, alu_opcode}), 32'({8'hFF, 8'h01, 3'b000}));
    chk("t1_issue_rsp_valid", 32'(bus.rsp_valid), 32'h0);
    step();
    chk("t1_rsp_valid", 32'(bus.rsp_valid), 32'h1);
    chk("t1_rsp", 32'({bus.rsp_carryout, bus.rsp_overflow, bus.rsp_zero, bus.rsp_result}), 32'h500);
    bus.rsp_ready = 2'b01;
    step();
    chk("t1_done_valid", 32'(bus.rsp_valid), 32'h0);
    chk("t1_done_busy", 32'(busy), 32'h0);
    chk("t1_alu_hold", 32'(alu_a), 32'hFF);

    // Both valid from reset: alternation 0, 1, 0
    pulse_reset();
    bus.req_valid = 2'b11; bus.rsp_ready = 2'b11;
    bus.req0_opcode = 3'b001; bus.req0_a = 8'h7F; bus.req0_b = 8'h01;
    bus.req1_opcode = 3'b100; bus.req1_a = 8'hD9; bus.req1_b = 8'h61;
    #1;
    chk("t2_first_grant", 32'(bus.req_ready), 32'h1);
    step(); step();
    chk("t2_rsp0_valid", 32'(bus.rsp_valid), 32'h1);
    chk("t2_rsp0", 32'({bus.rsp_carryout, bus.rsp_overflow, bus.rsp_zero, bus.rsp_result}), 32'h280);
    step();
    chk("t2_second_grant", 32'(bus.req_ready), 32'h2);
    step(); step();
    chk("t2_rsp1_valid", 32'(bus.rsp_valid), 32'h2);
    chk("t2_rsp1", 32'({bus.rsp_carryout, bus.rsp_overflow, bus.rsp_zero, bus.rsp_result}), 32'h041);
    step();
    chk("t2_third_grant", 32'(bus.req_ready), 32'h1);
    bus.req_valid = 2'b00;

    // Backpressure on requester 0: 91 - 28
    bus.rsp_ready = 2'b00;
    bus.req_valid = 2'b01; bus.req0_opcode = 3'b010; bus.req0_a = 8'h91; bus.req0_b = 8'h28;
    step();
    bus.req_valid = 2'b11;
    step();
    for (int i = 0; i < 5; i++) begin
      chk("t3_hold_valid", 32'(bus.rsp_valid), 32'h1);
      chk("t3_hold_result", 32'(bus.rsp_result), 32'h69);
      chk("t3_hold_ready", 32'(bus.req_ready), 32'h0);
      chk("t3_hold_busy", 32'(busy), 32'h1);
      step();
    end
    bus.rsp_ready = 2'b01; bus.req_valid = 2'b00;
    step();
    chk("t3_release_valid", 32'(bus.rsp_valid), 32'h0);
    chk("t3_release_busy", 32'(busy), 32'h0);

    // Wrong-owner ready is ignored: owner 1, F0 & 3C
    bus.req_valid = 2'b10; bus.req1_opcode = 3'b100; bus.req1_a = 8'hF0; bus.req1_b = 8'h3C;
    step();
    bus.req_valid = 2'b00;
    step();
    for (int i = 0; i < 3; i++) begin
      chk("t4_stuck_valid", 32'(bus.rsp_valid), 32'h2);
      chk("t4_stuck_result", 32'(bus.rsp_result), 32'h30);
      step();
    end
    bus.rsp_ready = 2'b10;
    step();
    chk("t4_owner_release", 32'(bus.rsp_valid), 32'h0);
    bus.rsp_ready = 2'b00;

    // Reset during ISSUE discards the operation and restores arbitration
    bus.req_valid = 2'b01; bus.req0_opcode = 3'b000; bus.req0_a = 8'h12; bus.req0_b = 8'h34;
    step();
    bus.req_valid = 2'b00;
    reset = 1'b0;
    #1;
    chk("t5_rst_valid", 32'(bus.rsp_valid), 32'h0);
    chk("t5_rst_busy", 32'(busy), 32'h0);
    chk("t5_rst_result", 32'(bus.rsp_result), 32'h0);
    chk("t5_rst_alu_a", 32'(alu_a), 32'h0);
    @(negedge clk);
    @(posedge clk);
    #1;
    reset = 1'b1;
    bus.req_valid = 2'b11; bus.rsp_ready = 2'b11;
    bus.req0_opcode = 3'b101; bus.req0_a = 8'h0F; bus.req0_b = 8'hF0;
    bus.req1_opcode = 3'b110; bus.req1_a = 8'hAA; bus.req1_b = 8'hFF;
    #1;
    chk("t5_grant_after_rst", 32'(bus.req_ready), 32'h1);
    step(); step();
    chk("t5_rsp", 32'({bus.rsp_valid, bus.rsp_result}), 32'h1FF);
    step();
    chk("t5_next_grant", 32'(bus.req_ready), 32'h2);
    bus.req_valid = 2'b00;

    // Shift-right from requester 1 alone, back-to-back with inputs churning
    hs_cyc.delete();
    bus.req_valid = 2'b10; bus.req1_opcode = 3'b111; bus.req1_a = 8'h60; bus.req1_b = 8'h00;
    step();
    bus.req1_a = 8'($urandom);
    step();
    chk("t6_rsp_valid", 32'(bus.rsp_valid), 32'h2);
    chk("t6_rsp", 32'({bus.rsp_carryout, bus.rsp_overflow, bus.rsp_zero, bus.rsp_result}), 32'h030);
    for (int i = 0; i < 7; i++) begin
      bus.req1_a = 8'($urandom);
      bus.req1_b = 8'($urandom);
      step();
    end
    bus.req_valid = 2'b00;
    chk("t6_hs_count", 32'(hs_cyc.size() >= 3), 32'h1);
    for (int i = 1; i < hs_cyc.size(); i++) chk("t6_hs_gap", 32'(hs_cyc[i] - hs_cyc[i-1]), 32'h3);
    drain();

    // Random traffic checked by the scoreboard
    for (int i = 0; i < 60; i++) begin
      bus.req_valid = 2'($urandom);
      bus.rsp_ready = 2'($urandom);
      bus.req0_a = 8'($urandom); bus.req0_b = 8'($urandom); bus.req0_opcode = 3'($urandom);
      bus.req1_a = 8'($urandom); bus.req1_b = 8'($urandom); bus.req1_opcode = 3'($urandom);
      step();
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
